// File: rtl/cam_types_pkg.sv
// Shared CAM types: key/value/error definitions plus the request record
// queued by cam_req_driver.
package cam_types;

   typedef logic [15:0] key_t;
   typedef logic [15:0] val_t;

   typedef enum logic [0:0] {
      NO_ERROR   = 1'b0,
      READ_ERROR = 1'b1
   } error_e;

   typedef enum logic [0:0] {
      CAM_READ  = 1'b0,
      CAM_WRITE = 1'b1
   } cam_op_e;

   typedef struct packed {
      cam_op_e op;
      key_t    key;
      val_t    val;
   } cam_req_t;

   parameter int req_fifo_depth_p = 4;

endpackage

// File: rtl/cam_req_driver_if.sv
// CAM-side operation bus: the driver strobes operations, the CAM returns
// read data and hit status one cycle after a read strobe.
interface cam_req_driver_if;
   import cam_types::*;

   logic cam_valid_o;
   logic cam_rw_n_o;
   key_t cam_key_o;
   val_t cam_val_o;
   val_t cam_rdata_i;
   logic cam_hit_i;

   modport master (
      output cam_valid_o,
      output cam_rw_n_o,
      output cam_key_o,
      output cam_val_o,
      input  cam_rdata_i,
      input  cam_hit_i
   );

   modport slave (
      input  cam_valid_o,
      input  cam_rw_n_o,
      input  cam_key_o,
      input  cam_val_o,
      output cam_rdata_i,
      output cam_hit_i
   );

endinterface

// File: rtl/cam_req_driver_fifo.sv
// Circular request FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module cam_req_fifo
   import cam_types::*;
#(
   parameter int DEPTH = req_fifo_depth_p
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  logic     pop,
   input  cam_req_t din,
   output cam_req_t dout,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   cam_req_t       mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage holds no control state, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/cam_req_driver.sv
// Queues read/write requests and issues them to a CAM in acceptance order,
// holding one read response at a time for the requester.
module cam_req_driver
   import cam_types::*;
#(
   parameter int DEPTH = req_fifo_depth_p
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_rw_n,
   input  key_t                  req_key,
   input  val_t                  req_val,
   cam_req_driver_if.master      cam,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output val_t                  resp_val,
   output logic                  resp_miss,
   output logic [7:0]            miss_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } state_e;

   state_e   state;
   error_e   resp_err;
   cam_req_t fifo_din;
   cam_req_t head;
   logic     fifo_full;
   logic     fifo_empty;
   logic     push;
   logic     issue;

   assign req_ready = !fifo_full;
   assign push      = req_valid && req_ready;

   // Read requests carry no data; store zero so the CAM bus stays quiet.
   always_comb begin
      fifo_din.op  = req_rw_n ? CAM_READ : CAM_WRITE;
      fifo_din.key = req_key;
      fifo_din.val = req_rw_n ? '0 : req_val;
   end

   cam_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (issue),
      .din   (fifo_din),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign issue           = (state == IDLE) && !fifo_empty;
   assign cam.cam_valid_o = issue;
   assign cam.cam_rw_n_o  = issue && (head.op == CAM_READ);
   assign cam.cam_key_o   = issue ? head.key : '0;
   assign cam.cam_val_o   = issue ? head.val : '0;

   assign resp_valid = (state == RESP);
   assign resp_miss  = (resp_err == READ_ERROR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         resp_val <= '0;
         resp_err <= NO_ERROR;
         miss_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue && (head.op == CAM_READ)) state <= RD_WAIT;
            end
            RD_WAIT: begin
               state <= RESP;
               if (cam.cam_hit_i) begin
                  resp_val <= cam.cam_rdata_i;
                  resp_err <= NO_ERROR;
               end else begin
                  resp_val <= '0;
                  resp_err <= READ_ERROR;
                  if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
               end
            end
            RESP: begin
               if (resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/cam_req_driver.md
CAM_REQ_DRIVER -- requirements
Module: cam_req_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request FIFO entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  requester offers a request.
REQ-005 SHALL have port req_ready  output  1  driver accepts a request this cycle.
REQ-006 SHALL have port req_rw_n  input  1  1 = read, 0 = write.
REQ-007 SHALL have port req_key  input  key_t  lookup or store key.
REQ-008 SHALL have port req_val  input  val_t  write data; ignored for reads.
REQ-009 SHALL have port cam_valid_o  output  1  one-cycle CAM operation strobe.
REQ-010 SHALL have port cam_rw_n_o  output  1  CAM operation type.
REQ-011 SHALL have port cam_key_o  output  key_t  CAM key.
REQ-012 SHALL have port cam_val_o  output  val_t  CAM write data.
REQ-013 SHALL have port cam_rdata_i  input  val_t  CAM read data, valid the cycle after a read strobe.
REQ-014 SHALL have port cam_hit_i  input  1  CAM read hit, same timing as cam_rdata_i.
REQ-015 SHALL have port resp_valid  output  1  read response held for the requester.
REQ-016 SHALL have port resp_ready  input  1  requester accepts the response.
REQ-017 SHALL have port resp_val  output  val_t  read data; '0 on a miss.
REQ-018 SHALL have port resp_miss  output  1  read missed (READ_ERROR).
REQ-019 SHALL have port miss_cnt  output  8  saturating count of read misses.

Function
REQ-020 SHALL accept a request when req_valid and req_ready are both 1; req_ready SHALL equal not-full, with no bypass.
REQ-021 SHALL keep requests in a circular FIFO with wrap-around pointers; requests SHALL issue to the CAM in strict acceptance order.
REQ-022 SHALL implement FSM states IDLE, RD_WAIT and RESP.
REQ-023 In IDLE with the FIFO non-empty, SHALL drive cam_valid_o=1 and cam_* combinationally from the FIFO head, then pop the head at the clock edge.
REQ-024 After a write issue, SHALL stay in IDLE; a write SHALL produce no response, and back-to-back writes SHALL issue one per cycle.
REQ-025 After a read issue, SHALL go to RD_WAIT; in RD_WAIT it SHALL sample cam_rdata_i and cam_hit_i into the response register and go to RESP.
REQ-026 In RESP, SHALL hold resp_valid=1 with stable resp_val and resp_miss until resp_ready=1, then return to IDLE.
REQ-027 SHALL drive cam_valid_o=0 in RD_WAIT and RESP; no issue while a read is outstanding.
REQ-028 SHALL keep accepting requests in every state while the FIFO is not full.
REQ-029 Latency: a request accepted in cycle N into an empty FIFO in IDLE SHALL strobe in N+1; for a read, resp_valid SHALL rise in N+3.
REQ-030 On a read miss, SHALL set resp_miss=1 and resp_val='0, and increment miss_cnt, saturating at 255.
REQ-031 SHALL drive cam_key_o, cam_val_o and cam_rw_n_o to 0 when cam_valid_o=0.

Reset
REQ-032 SHALL, on rst_n=0 at any time, empty the FIFO, enter IDLE, clear miss_cnt and the response register, and discard any outstanding read.
REQ-033 Reset values SHALL be: req_ready=1, cam_valid_o=0, resp_valid=0, resp_miss=0, resp_val=0, miss_cnt=0.

Structure
REQ-034 SHALL add to the cam_types package: enum cam_op_e (CAM_READ, CAM_WRITE); packed struct cam_req_t (op, key, val); parameter req_fifo_depth_p=4.
REQ-035 SHALL reuse key_t, val_t and error_e from cam_types, and SHALL NOT redefine them.
REQ-036 SHALL implement the FIFO as one sub-module, cam_req_fifo, with ports push, pop, din, dout, full and empty.

Verification
REQ-037 Write key 16'h1234 val 16'hBEEF, then read key 16'h1234 -> one write strobe, then read strobe; hit response resp_val=16'hBEEF, resp_miss=0, resp_valid in N+3.
REQ-038 Read key 16'h0055 with cam_hit_i=0 -> resp_miss=1, resp_val=0, miss_cnt=1; 300 misses -> miss_cnt=255.
REQ-039 Push 4 writes with the CAM stalled behind a read, resp_ready=0 -> req_ready=0 after the 4th; a 5th request is not accepted; order preserved after resp_ready=1.
REQ-040 Hold resp_ready=0 for 10 cycles -> resp_valid and resp_val stable and no cam_valid_o for all 10 cycles; one cycle after resp_ready=1, the next head issues.
REQ-041 Assert rst_n=0 in RD_WAIT with 3 entries queued -> outputs at reset values immediately; no response or strobe after release.
REQ-042 Push 9 alternating reads and writes through DEPTH=4 -> FIFO pointers wrap; CAM strobes match acceptance order exactly.
